// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package chronos_pkg;

  localparam int          DEFAULT_XLEN     = 32;
  localparam logic [31:0] DEFAULT_NOP_INST = 32'h0000_0013;
  localparam logic [6:0]  OPC_JAL          = 7'b1101111;

  typedef enum logic [1:0] {
    REQ,
    WAIT,
    DROP
  } fetch_state_t;

  typedef struct packed {
    logic [DEFAULT_XLEN-1:0] pc;
    logic [31:0]             inst;
    logic                    pred;
  } fq_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
interface fetch_unit_if #(
  parameter int XLEN = chronos_pkg::DEFAULT_XLEN
);

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [31:0]     imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata
  );

endinterface

// File: rtl/fetch_unit_fifo.sv
// Synchronous IF/ID fetch queue with flush, occupancy count and same-cycle push/pop.
module fetch_fifo
  import chronos_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic                       pop,
  input  fq_entry_t                  wdata,
  output fq_entry_t                  head,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);

  fq_entry_t       mem [DEPTH];
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic            full;
  logic            empty;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A pop frees the slot, so a push into a full queue is fine in the same cycle.
  assign do_push = push && !flush && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC generation, single-outstanding imem handshake, IF/ID queue.
// Optional JAL predecode redirect is enabled by defining CHRONOS_FETCH_JAL_PREDICT_EN.
module fetch_unit
  import chronos_pkg::*;
#(
  parameter int              XLEN     = DEFAULT_XLEN,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              FQ_DEPTH = 4,
  parameter logic [31:0]     NOP_INST = DEFAULT_NOP_INST
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  fetch_unit_if.master    imem,
  output logic            id_valid,
  output logic [31:0]     id_inst,
  output logic [XLEN-1:0] id_pc,
  output logic            id_pred,
  input  logic            id_ready,
  input  logic            nop_sel
);

  localparam int CW = $clog2(FQ_DEPTH + 1);

  fetch_state_t    state;
  fetch_state_t    state_next;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_next;
  logic [XLEN-1:0] req_pc;
  logic [XLEN-1:0] req_pc_next;
  logic [CW-1:0]   count;
  logic            issue;
  logic            push;
  logic            pop;
  logic            has_entry;
  fq_entry_t       push_entry;
  fq_entry_t       head;

  // The count check keeps one slot free for the response of the request being issued.
  assign issue = !rst && (state == REQ) && en && !redirect_valid &&
                 (count < CW'(FQ_DEPTH));

  assign imem.imem_req  = issue;
  assign imem.imem_addr = pc;

  assign has_entry = (count != '0);
  assign pop       = has_entry && id_ready && !nop_sel;

`ifdef CHRONOS_FETCH_JAL_PREDICT_EN
  logic [31:0]     jal_imm;
  logic [XLEN-1:0] jal_target;

  assign jal_imm = {{11{imem.imem_rdata[31]}}, imem.imem_rdata[31], imem.imem_rdata[19:12],
                    imem.imem_rdata[20], imem.imem_rdata[30:21], 1'b0};
  assign jal_target = req_pc + XLEN'($signed(jal_imm));
`endif

  always_comb begin
    push_entry.pc   = req_pc;
    push_entry.inst = imem.imem_rdata;
    push_entry.pred = 1'b0;
`ifdef CHRONOS_FETCH_JAL_PREDICT_EN
    push_entry.pred = (imem.imem_rdata[6:0] == OPC_JAL);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= REQ;
      pc     <= RESET_PC;
      req_pc <= RESET_PC;
    end else begin
      state  <= state_next;
      pc     <= pc_next;
      req_pc <= req_pc_next;
    end
  end

  // Redirect outranks everything; otherwise walk REQ -> WAIT -> REQ, or DROP a stale response.
  always_comb begin
    state_next  = state;
    pc_next     = pc;
    req_pc_next = req_pc;
    push        = 1'b0;

    if (redirect_valid) begin
      pc_next = redirect_pc & ~XLEN'(3);
      unique case (state)
        REQ:     state_next = imem.imem_gnt ? DROP : REQ;
        WAIT:    state_next = imem.imem_rvalid ? REQ : DROP;
        DROP:    state_next = DROP;
        default: state_next = REQ;
      endcase
    end else begin
      unique case (state)
        REQ: begin
          if (issue && imem.imem_gnt) begin
            req_pc_next = pc;
            pc_next     = pc + XLEN'(4);
            state_next  = WAIT;
          end
        end
        WAIT: begin
          if (imem.imem_rvalid) begin
            push       = 1'b1;
            state_next = REQ;
`ifdef CHRONOS_FETCH_JAL_PREDICT_EN
            if (push_entry.pred) pc_next = jal_target;
`endif
          end
        end
        DROP: begin
          if (imem.imem_rvalid) state_next = REQ;
        end
        default: state_next = REQ;
      endcase
    end
  end

  fetch_fifo #(
    .DEPTH (FQ_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect_valid),
    .push  (push),
    .pop   (pop),
    .wdata (push_entry),
    .head  (head),
    .count (count)
  );

  // Bubble injection shows the head PC but never consumes the entry.
  assign id_valid = has_entry || nop_sel;
  assign id_inst  = nop_sel ? NOP_INST : (has_entry ? head.inst : 32'h0);
  assign id_pc    = has_entry ? head.pc : '0;
  assign id_pred  = (has_entry && !nop_sel) ? head.pred : 1'b0;

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Parametrised instruction-fetch stage: PC generation, a single-outstanding instruction-memory handshake, and an IF/ID fetch queue.
Replaces the bare PC register / PC+4 / NOP-mux arrangement.
Adds branch/redirect flushing, stale-response dropping, back-pressure from decode, and bubble injection.
Sits between instruction memory and the decoder.

Parameters:
XLEN, 32, datapath and PC width
RESET_PC, 32'h0000_0000, PC value after reset
FQ_DEPTH, 4, fetch-queue entries; power of two, at least 2
NOP_INST, 32'h0000_0013, instruction driven on bubble injection (addi x0,x0,0)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
en  in  1  fetch enable; 0 stops new requests
redirect_valid  in  1  pipeline redirect (branch resolve, kill)
redirect_pc  in  XLEN  redirect target
imem_req  out  1  request valid to instruction memory
imem_addr  out  XLEN  request address
imem_gnt  in  1  memory accepts request this cycle
imem_rvalid  in  1  response valid
imem_rdata  in  32  response instruction
id_valid  out  1  instruction available to decode
id_inst  out  32  instruction to decode
id_pc  out  XLEN  PC of id_inst
id_pred  out  1  fetch-predicted-taken flag (see optional feature)
id_ready  in  1  decode consumes this cycle
nop_sel  in  1  inject bubble into decode

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-high on rst.
- Reset results:
  - pc = RESET_PC; state REQ; queue count 0.
  - All outputs 0 except imem_addr = RESET_PC.
- States:
  - REQ: may issue.
  - WAIT: one request granted, response pending.
  - DROP: granted request is stale; discard its response.
- Issue condition in REQ: en=1, no redirect_valid, and count < FQ_DEPTH, so one slot is always reserved for the outstanding response.
  - While issuing, imem_req=1 and imem_addr=pc, held stable until imem_gnt.
  - On the gnt cycle: capture req_pc=pc, pc <= pc+4 (mod 2^XLEN, wraps), state goes to WAIT.
- WAIT behaviour:
  - imem_rvalid pushes {req_pc, imem_rdata} into the queue, then state goes to REQ.
  - Earliest next request is the following cycle; issue latency is 1 cycle after the response.
- imem_rvalid while in REQ is ignored; this covers in-flight responses across reset.
- Redirect has highest priority:
  - pc <= {redirect_pc[XLEN-1:2], 2'b00}; queue flushed (count 0).
  - In WAIT without a same-cycle rvalid, state goes to DROP.
  - In WAIT with a same-cycle rvalid, the response is discarded and state goes to REQ.
  - In REQ with imem_gnt=1 in the same cycle, state goes to DROP.
  - Otherwise state goes to REQ.
- DROP: discard the next rvalid, then go to REQ. A redirect in DROP updates pc and stays in DROP.
- Decode output:
  - id_valid = count != 0.
  - id_inst and id_pc come from the queue head.
  - Pop occurs when id_valid && id_ready && !nop_sel.
  - Push and pop in the same cycle are legal at any count.
- nop_sel=1: id_valid=1, id_inst=NOP_INST, id_pc=head PC (0 if empty), id_pred=0, no pop.
- en=0: no new issue. An outstanding response still completes and pushes. The queue still drains.
- Queue full: no issue. A full queue together with an outstanding response is unreachable by construction.

Optional Feature:
Macro CHRONOS_FETCH_JAL_PREDICT_EN.
- Defined:
  - On an accepted response whose opcode[6:0] = 7'b1101111 (JAL), pc <= req_pc + sign-extended J-immediate, overriding the sequential pc+4.
  - The pushed entry carries pred=1, and id_pred reflects the head entry.
  - A same-cycle redirect still wins.
- Undefined: no predecode; id_pred is tied 0 and the port remains present.

Decomposition:
- Shared package chronos_pkg:
  - XLEN default.
  - NOP_INST.
  - OPC_JAL.
  - fetch_state_t enum {REQ, WAIT, DROP}.
  - fq_entry_t struct {pc, inst, pred}.
- One sub-module, fetch_fifo: parametrised synchronous FIFO with flush, count output and a same-cycle push/pop path.
- Controller and PC logic stay in fetch_unit.

Test Plan:
1. Reset, then imem_gnt=1 and rvalid 1 cycle later, id_ready=0 -> addresses 0x0, 0x4, 0x8, 0xC issued; the 5th is not issued (FQ_DEPTH=4); id_pc=0x0.
2. Request pending at 0x8 with gnt withheld 3 cycles -> imem_req=1 and imem_addr=0x8 stable throughout; pc reaches 0xC only on the gnt cycle.
3. In WAIT, redirect_pc=0x103 -> queue empties, state DROP; the next rvalid (0xDEADBEEF) is not pushed; next imem_addr=0x100.
4. Head 0x00500093 with nop_sel=1 for 2 cycles, id_ready=1 -> id_inst=0x00000013 both cycles; then 0x00500093 is popped, exactly once.
5. Same-cycle rvalid and redirect -> response dropped, state REQ, no DROP; the following rvalid-free cycle issues redirect target.
6. With CHRONOS_FETCH_JAL_PREDICT_EN, response 0x0100006F at PC 0x20 -> next imem_addr=0x30, id_pred=1; without the macro -> next imem_addr=0x24, id_pred=0.
